// File: rtl/score_accumulator_pkg.sv
// Shared definitions for the scoring pipeline.
// The judgement codes are also used by the score-conversion stage.
package score_accumulator_pkg;

    localparam logic [1:0] JUDGE_PERFECT = 2'b00;
    localparam logic [1:0] JUDGE_GOOD    = 2'b01;
    localparam logic [1:0] JUDGE_MISS    = 2'b10;
    localparam logic [1:0] JUDGE_NO_NOTE = 2'b11;

    localparam int unsigned COMBO_MAX_DEFAULT = 999;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PLAYING = 2'b01,
        DONE    = 2'b10
    } state_t;

    // Number of lanes (0..2) carrying the given judgement code.
    function automatic logic [1:0] lane_count(input logic [1:0] up,
                                              input logic [1:0] down,
                                              input logic [1:0] code);
        return 2'(up == code) + 2'(down == code);
    endfunction

endpackage

// File: rtl/sat_add_counter.sv
// Counter that adds a per-cycle increment and saturates at a programmable ceiling.
// The next value is exported so callers can compare against it in the same cycle.
module sat_add_counter #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] inc,
    input  logic [W-1:0] max,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] value,
    output logic [W-1:0] value_nxt_c
);

    logic [W:0] sum_c;

    assign sum_c = {1'b0, value} + {1'b0, inc};

    // Clear wins over increment.
    always_comb begin
        value_nxt_c = value;
        if (clear) begin
            value_nxt_c = '0;
        end else if (en) begin
            if (sum_c > {1'b0, max}) begin
                value_nxt_c = max;
            end else begin
                value_nxt_c = sum_c[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else begin
            value <= value_nxt_c;
        end
    end

endmodule

// File: rtl/score_accumulator.sv
// Per-song score, combo and hit-count accumulator with the IDLE/PLAYING/DONE song state.
// start always wins: it clears statistics and (re)enters PLAYING, discarding any same-cycle tick.
module score_accumulator
    import score_accumulator_pkg::*;
#(
    parameter int unsigned TOTAL_W   = 24,
    parameter int unsigned COMBO_MAX = COMBO_MAX_DEFAULT,
    parameter int unsigned CNT_W     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               song_end,
    input  logic               judge_valid,
    input  logic [1:0]         judgement_up,
    input  logic [1:0]         judgement_down,
    input  logic [15:0]        score,
    output logic [TOTAL_W-1:0] total_score,
    output logic [CNT_W-1:0]   combo,
    output logic [CNT_W-1:0]   max_combo,
    output logic [CNT_W-1:0]   perfect_cnt,
    output logic [CNT_W-1:0]   good_cnt,
    output logic [CNT_W-1:0]   miss_cnt,
    output logic               playing,
    output logic               done
);

    localparam int unsigned SUM_W = TOTAL_W + 1;

    state_t             state;
    state_t             state_nxt;
    logic               clr_c;
    logic               tick_c;

    logic [1:0]         n_perfect_c;
    logic [1:0]         n_good_c;
    logic [1:0]         n_miss_c;
    logic [1:0]         n_hit_c;
    logic               miss_any_c;

    logic [SUM_W-1:0]   total_sum_c;
    logic [TOTAL_W-1:0] total_nxt_c;
    logic [CNT_W-1:0]   combo_nxt_c;
    logic [CNT_W-1:0]   perfect_nxt_c;
    logic [CNT_W-1:0]   good_nxt_c;
    logic [CNT_W-1:0]   miss_nxt_c;

    // Song state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, clear and tick qualification.
    always_comb begin
        state_nxt = state;
        clr_c     = start;
        tick_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PLAYING;
                end
            end
            PLAYING: begin
                if (!start) begin
                    tick_c = judge_valid;
                    if (song_end) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = PLAYING;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign n_perfect_c = lane_count(judgement_up, judgement_down, JUDGE_PERFECT);
    assign n_good_c    = lane_count(judgement_up, judgement_down, JUDGE_GOOD);
    assign n_miss_c    = lane_count(judgement_up, judgement_down, JUDGE_MISS);
    assign n_hit_c     = n_perfect_c + n_good_c;
    assign miss_any_c  = (n_miss_c != 2'd0);

    // A miss on either lane breaks the combo regardless of the other lane.
    sat_add_counter #(.W(CNT_W)) u_combo (
        .clk         (clk),
        .rst         (rst),
        .inc         (CNT_W'(n_hit_c)),
        .max         (CNT_W'(COMBO_MAX)),
        .clear       (clr_c | (tick_c & miss_any_c)),
        .en          (tick_c),
        .value       (combo),
        .value_nxt_c (combo_nxt_c)
    );

    sat_add_counter #(.W(CNT_W)) u_perfect_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc         (CNT_W'(n_perfect_c)),
        .max         ({CNT_W{1'b1}}),
        .clear       (clr_c),
        .en          (tick_c),
        .value       (perfect_cnt),
        .value_nxt_c (perfect_nxt_c)
    );

    sat_add_counter #(.W(CNT_W)) u_good_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc         (CNT_W'(n_good_c)),
        .max         ({CNT_W{1'b1}}),
        .clear       (clr_c),
        .en          (tick_c),
        .value       (good_cnt),
        .value_nxt_c (good_nxt_c)
    );

    sat_add_counter #(.W(CNT_W)) u_miss_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc         (CNT_W'(n_miss_c)),
        .max         ({CNT_W{1'b1}}),
        .clear       (clr_c),
        .en          (tick_c),
        .value       (miss_cnt),
        .value_nxt_c (miss_nxt_c)
    );

    // Saturating total: the extra sum bit flags overflow.
    assign total_sum_c = {1'b0, total_score} + SUM_W'(score);

    always_comb begin
        total_nxt_c = total_score;
        if (clr_c) begin
            total_nxt_c = '0;
        end else if (tick_c) begin
            if (total_sum_c[TOTAL_W]) begin
                total_nxt_c = '1;
            end else begin
                total_nxt_c = total_sum_c[TOTAL_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_score <= '0;
        end else begin
            total_score <= total_nxt_c;
        end
    end

    // max_combo tracks the combo value being written this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_combo <= '0;
        end else if (clr_c) begin
            max_combo <= '0;
        end else if (tick_c && (combo_nxt_c > max_combo)) begin
            max_combo <= combo_nxt_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            playing <= 1'b0;
            done    <= 1'b0;
        end else begin
            playing <= (state_nxt == PLAYING);
            done    <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_score_accumulator.sv
// Self-checking bench for score_accumulator: directed scenarios plus randomized
// traffic, compared every cycle against an integer behavioural model.
module tb_score_accumulator;
    import score_accumulator_pkg::*;

    localparam int unsigned TOTAL_W = 24;
    localparam int unsigned CNT_W   = 10;
    localparam int          CMAX    = 999;
    localparam longint      TOT_SAT = (longint'(1) << TOTAL_W) - 1;
    localparam int          CNT_SAT = (1 << CNT_W) - 1;

    localparam logic [1:0] P = JUDGE_PERFECT;
    localparam logic [1:0] G = JUDGE_GOOD;
    localparam logic [1:0] M = JUDGE_MISS;
    localparam logic [1:0] N = JUDGE_NO_NOTE;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               song_end = 1'b0;
    logic               judge_valid = 1'b0;
    logic [1:0]         judgement_up = 2'b11;
    logic [1:0]         judgement_down = 2'b11;
    logic [15:0]        score = 16'd0;
    logic [TOTAL_W-1:0] total_score;
    logic [CNT_W-1:0]   combo;
    logic [CNT_W-1:0]   max_combo;
    logic [CNT_W-1:0]   perfect_cnt;
    logic [CNT_W-1:0]   good_cnt;
    logic [CNT_W-1:0]   miss_cnt;
    logic               playing;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = idle, 1 = playing, 2 = done.
    int     m_state;
    longint m_total;
    int     m_combo, m_max, m_perf, m_good, m_miss;

    score_accumulator dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .song_end       (song_end),
        .judge_valid    (judge_valid),
        .judgement_up   (judgement_up),
        .judgement_down (judgement_down),
        .score          (score),
        .total_score    (total_score),
        .combo          (combo),
        .max_combo      (max_combo),
        .perfect_cnt    (perfect_cnt),
        .good_cnt       (good_cnt),
        .miss_cnt       (miss_cnt),
        .playing        (playing),
        .done           (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        m_total = 0;
        m_combo = 0;
        m_max   = 0;
        m_perf  = 0;
        m_good  = 0;
        m_miss  = 0;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_tick(input logic [1:0] ju, input logic [1:0] jd, input logic [15:0] sc);
        logic [1:0] lanes[2];
        int np = 0, ng = 0, nm = 0;
        lanes[0] = ju;
        lanes[1] = jd;
        foreach (lanes[i]) begin
            if (lanes[i] == P) np++;
            else if (lanes[i] == G) ng++;
            else if (lanes[i] == M) nm++;
        end
        m_total = m_total + longint'(sc);
        if (m_total > TOT_SAT) m_total = TOT_SAT;
        m_combo = (nm > 0) ? 0 : min_i(m_combo + np + ng, CMAX);
        if (m_combo > m_max) m_max = m_combo;
        m_perf = min_i(m_perf + np, CNT_SAT);
        m_good = min_i(m_good + ng, CNT_SAT);
        m_miss = min_i(m_miss + nm, CNT_SAT);
    endfunction

    function automatic void model_step(input logic s, input logic e, input logic v,
                                       input logic [1:0] ju, input logic [1:0] jd,
                                       input logic [15:0] sc);
        if (s) begin
            model_clear();
            m_state = 1;
        end else if (m_state == 1) begin
            if (v) model_tick(ju, jd, sc);
            if (e) m_state = 2;
        end
    endfunction

    task automatic check_all(input string ctx);
        check({ctx, ":total_score"}, 32'(total_score), 32'(m_total));
        check({ctx, ":combo"},       32'(combo),       32'(m_combo));
        check({ctx, ":max_combo"},   32'(max_combo),   32'(m_max));
        check({ctx, ":perfect_cnt"}, 32'(perfect_cnt), 32'(m_perf));
        check({ctx, ":good_cnt"},    32'(good_cnt),    32'(m_good));
        check({ctx, ":miss_cnt"},    32'(miss_cnt),    32'(m_miss));
        check({ctx, ":playing"},     32'(playing),     32'(m_state == 1));
        check({ctx, ":done"},        32'(done),        32'(m_state == 2));
    endtask

    // One clock: drive, let the edge sample, advance the model, check just after the edge.
    task automatic step(input string ctx, input logic s, input logic e, input logic v,
                        input logic [1:0] ju, input logic [1:0] jd, input logic [15:0] sc);
        start          = s;
        song_end       = e;
        judge_valid    = v;
        judgement_up   = ju;
        judgement_down = jd;
        score          = sc;
        @(posedge clk);
        model_step(s, e, v, ju, jd, sc);
        #1;
        start       = 1'b0;
        song_end    = 1'b0;
        judge_valid = 1'b0;
        check_all(ctx);
    endtask

    function automatic logic [1:0] rand_judge();
        int r = int'($urandom_range(0, 9));
        if (r < 5) return P;
        if (r < 7) return G;
        if (r < 8) return M;
        return N;
    endfunction

    initial begin
        m_state = 0;
        model_clear();

        // Reset and idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset:total_score", 32'(total_score), 32'd0);
        check("reset:playing", 32'(playing), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        rst = 1'b0;
        step("idle_tick", 1'b0, 1'b0, 1'b1, P, P, 16'd300);
        check("idle_tick:total", 32'(total_score), 32'd0);
        step("idle_end", 1'b0, 1'b1, 1'b0, N, N, 16'd0);
        check("idle_end:done", 32'(done), 32'd0);

        // Basic accumulation
        step("start", 1'b1, 1'b0, 1'b0, N, N, 16'd0);
        check("start:playing", 32'(playing), 32'd1);
        step("tick1", 1'b0, 1'b0, 1'b1, P, N, 16'd300);
        check("tick1:total", 32'(total_score), 32'd300);
        check("tick1:combo", 32'(combo), 32'd1);
        check("tick1:perfect", 32'(perfect_cnt), 32'd1);
        step("tick2", 1'b0, 1'b0, 1'b1, G, N, 16'd100);
        check("tick2:total", 32'(total_score), 32'd400);
        check("tick2:combo", 32'(combo), 32'd2);
        check("tick2:good", 32'(good_cnt), 32'd1);
        step("tick3", 1'b0, 1'b0, 1'b1, G, P, 16'd400);
        check("tick3:total", 32'(total_score), 32'd800);
        check("tick3:combo", 32'(combo), 32'd4);
        check("tick3:max_combo", 32'(max_combo), 32'd4);
        check("tick3:perfect", 32'(perfect_cnt), 32'd2);
        check("tick3:good", 32'(good_cnt), 32'd2);

        // Miss handling
        step("miss", 1'b0, 1'b0, 1'b1, M, P, 16'd300);
        check("miss:combo", 32'(combo), 32'd0);
        check("miss:max_combo", 32'(max_combo), 32'd4);
        check("miss:miss_cnt", 32'(miss_cnt), 32'd1);
        check("miss:perfect", 32'(perfect_cnt), 32'd3);
        step("after_miss", 1'b0, 1'b0, 1'b1, P, N, 16'd0);
        check("after_miss:combo", 32'(combo), 32'd1);
        check("after_miss:max_combo", 32'(max_combo), 32'd4);

        // Combo and counter saturation
        step("sat_start", 1'b1, 1'b0, 1'b0, N, N, 16'd0);
        repeat (500) step("sat_pp", 1'b0, 1'b0, 1'b1, P, P, 16'd10);
        check("sat:combo", 32'(combo), 32'd999);
        check("sat:max_combo", 32'(max_combo), 32'd999);
        check("sat:perfect", 32'(perfect_cnt), 32'd1000);
        repeat (12) step("sat_pp2", 1'b0, 1'b0, 1'b1, P, P, 16'd10);
        check("sat:perfect_held", 32'(perfect_cnt), 32'd1023);

        // Total saturation
        step("tot_start", 1'b1, 1'b0, 1'b0, N, N, 16'd0);
        repeat (257) step("tot_add", 1'b0, 1'b0, 1'b1, N, N, 16'hFFFF);
        check("tot:total_sat", 32'(total_score), 32'd16777215);
        check("tot:combo", 32'(combo), 32'd0);

        // Simultaneous events
        step("se_start", 1'b1, 1'b0, 1'b0, N, N, 16'd0);
        step("end_tick", 1'b0, 1'b1, 1'b1, P, N, 16'd300);
        check("end_tick:total", 32'(total_score), 32'd300);
        check("end_tick:done", 32'(done), 32'd1);
        step("done_tick", 1'b0, 1'b0, 1'b1, P, P, 16'd500);
        check("done_tick:total", 32'(total_score), 32'd300);
        check("done_tick:combo", 32'(combo), 32'd1);
        step("done_end", 1'b0, 1'b1, 1'b0, N, N, 16'd0);
        step("start_tick", 1'b1, 1'b0, 1'b1, P, P, 16'd500);
        check("start_tick:total", 32'(total_score), 32'd0);
        check("start_tick:perfect", 32'(perfect_cnt), 32'd0);
        check("start_tick:playing", 32'(playing), 32'd1);
        step("restart_tick", 1'b0, 1'b0, 1'b1, G, G, 16'd50);
        step("restart_both", 1'b1, 1'b1, 1'b1, M, M, 16'd70);
        check("restart_both:playing", 32'(playing), 32'd1);

        // Reset mid-operation
        step("pre_rst1", 1'b0, 1'b0, 1'b1, P, G, 16'd123);
        step("pre_rst2", 1'b0, 1'b0, 1'b1, P, M, 16'd77);
        #2;
        rst = 1'b1;
        #1;
        check("midrst:total", 32'(total_score), 32'd0);
        check("midrst:perfect", 32'(perfect_cnt), 32'd0);
        check("midrst:miss", 32'(miss_cnt), 32'd0);
        check("midrst:playing", 32'(playing), 32'd0);
        #1;
        rst = 1'b0;
        m_state = 0;
        model_clear();
        step("post_rst", 1'b0, 1'b0, 1'b1, P, P, 16'd300);
        check("post_rst:playing", 32'(playing), 32'd0);
        check("post_rst:total", 32'(total_score), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 9) < 7),
                 rand_judge(), rand_judge(),
                 ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                             : 16'($urandom_range(0, 1000)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_accumulator.md
# score_accumulator

Per-song scoring state machine that sits directly downstream of the score-conversion stage. Each judgement tick it consumes the two lane judgements (up/down) and the 16-bit per-tick score produced for them. It maintains the running total, the current combo, the max combo and per-category hit counts for the display/result logic. It also owns the song-level IDLE/PLAYING/DONE state.

## Interface
Parameters:
- TOTAL_W, 24, width of the total score accumulator
- COMBO_MAX, 999, saturation value of combo and max_combo
- CNT_W, 10, width of combo, max_combo and the hit counters

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high; one clock, no other clock domains
- start  in  1  one-cycle pulse: begin or restart a song
- song_end  in  1  one-cycle pulse: chart finished
- judge_valid  in  1  one-cycle strobe: judgement_up/down/score are valid this cycle
- judgement_up  in  2  up-lane judgement: 00 PERFECT, 01 GOOD, 10 MISS, 11 NO_NOTE
- judgement_down  in  2  down-lane judgement, same encoding
- score  in  16  per-tick score from the score-conversion stage (unsigned)
- total_score  out  TOTAL_W  accumulated score
- combo  out  CNT_W  current combo
- max_combo  out  CNT_W  highest combo this song
- perfect_cnt / good_cnt / miss_cnt  out  CNT_W each  lane-hit counts
- playing  out  1  high in PLAYING
- done  out  1  high in DONE

## Operation
- States are IDLE (reset state), PLAYING and DONE.
- IDLE: start goes to PLAYING. song_end and judge_valid are ignored.
- PLAYING:
  - start clears all statistics and stays in PLAYING (restart).
  - song_end goes to DONE.
  - judge_valid applies a tick.
- DONE: all statistics hold. start clears them and goes to PLAYING. judge_valid and song_end are ignored.
- Clearing sets total_score, combo, max_combo and all counters to 0.
- Tick update (PLAYING, judge_valid=1, start=0):
  - total_score += score, zero-extended, saturating at 2^TOTAL_W-1.
  - hit count h = number of lanes (0..2) judged PERFECT or GOOD.
  - If either lane is MISS, combo becomes 0. A MISS on one lane resets combo even if the other lane hits.
  - Otherwise combo becomes min(combo+h, COMBO_MAX).
  - max_combo becomes max(max_combo, new combo), computed from the new combo value in the same cycle.
  - perfect_cnt, good_cnt and miss_cnt each add the number of lanes (0..2) with that judgement, each saturating at 2^CNT_W-1.
  - NO_NOTE on both lanes leaves combo and all counters unchanged. score is still added; it is expected to be 0.
- Simultaneous events:
  - start has priority over song_end and judge_valid in every state; the result is clear and PLAYING, and the tick is discarded.
  - song_end with judge_valid in PLAYING applies the tick, then enters DONE.

## Timing
- All outputs are registered. A tick sampled at edge N is visible after edge N.
- Latency is 1 cycle. Throughput is one tick per cycle; back-to-back judge_valid is legal.
- The state transition and the first clear take effect at the edge that samples start. playing is high from the next cycle.
- Reset values: all outputs 0 except playing=0, done=0 (state IDLE).
- rst asserted mid-song forces IDLE and zeros immediately (asynchronously), regardless of in-flight strobes.
- Inputs are sampled only at the rising edge. judgement and score values outside a judge_valid cycle are don't-care.

## Structure
- The shared package holds:
  - judgement codes JUDGE_PERFECT=2'b00, JUDGE_GOOD=2'b01, JUDGE_MISS=2'b10, JUDGE_NO_NOTE=2'b11, also used by the score-conversion stage;
  - the state enum {IDLE, PLAYING, DONE};
  - the default COMBO_MAX.
- One sub-module, sat_add_counter, handles the saturating add. It has parameter W and ports value, inc, max, clear and en. It is instantiated for combo and the three hit counters.
- The total accumulator and max_combo compare stay inline.

## Test plan
- **Reset and idle:** assert rst; pulse judge_valid with score=300 while IDLE -> all outputs 0, playing=0, done=0.
- **Basic accumulation:** start; then ticks (up PERFECT, down NO_NOTE, score=300), (GOOD, NO_NOTE, 100), (GOOD, PERFECT, 400), back-to-back:
  - after tick 1: total_score=300, combo=1, perfect_cnt=1;
  - after tick 2: total_score=400, combo=2, good_cnt=1;
  - after tick 3: total_score=800, combo=4, max_combo=4, perfect_cnt=2, good_cnt=2.
- **Miss handling:** from combo=4, tick (MISS, PERFECT, 300) -> combo=0, max_combo=4, miss_cnt=1, perfect_cnt increments; then (PERFECT, NO_NOTE) -> combo=1, max_combo stays 4.
- **Saturation:** 500 ticks of (PERFECT, PERFECT) -> combo=999, max_combo=999, perfect_cnt=1000. A further 12 such ticks -> perfect_cnt=1023 held. Separately, total_score preloaded near the limit by repeated score=65535 stops at 16777215.
- **Simultaneous events:**
  - song_end with a (PERFECT, NO_NOTE, 300) tick -> tick counted, done=1.
  - Subsequent ticks are ignored in DONE.
  - start together with judge_valid -> all cleared, tick discarded, playing=1.
- **Reset mid-operation:** mid-song with nonzero stats, pulse rst between edges -> outputs zero before the next edge; state is IDLE after release.
